// File: rtl/reg_file_banked_if.sv
// Decode-side bus of the banked register file: two write ports, NUM_RD read ports and the bank swap strobe.
// Every signal is a per-cycle strobe sampled on the rising edge; there is no valid/ready backpressure.
interface reg_file_banked_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int NUM_RD = 2
) ();
   logic [NUM_RD-1:0]        rd_en;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_val_o;
   logic                     wen0;
   logic                     wen1;
   logic [ADDR_W-1:0]        waddr0;
   logic [ADDR_W-1:0]        waddr1;
   logic [DATA_W-1:0]        wdata0;
   logic [DATA_W-1:0]        wdata1;
   logic                     swap;
   logic                     bank_o;

   modport master (
      output rd_en, rd_addr, wen0, wen1, waddr0, waddr1, wdata0, wdata1, swap,
      input  rd_val_o, bank_o
   );

   modport slave (
      input  rd_en, rd_addr, wen0, wen1, waddr0, waddr1, wdata0, wdata1, swap,
      output rd_val_o, bank_o
   );
endinterface

// File: rtl/reg_file_banked.sv
// Two-bank register file with dual write ports, NUM_RD registered read ports,
// optional write-first bypass and optional hardwired-zero register 0.
module reg_file_banked #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 4,
   parameter int NUM_RD   = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0
) (
   input logic              clk,
   input logic              reset_n,
   reg_file_banked_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0]        mem [2][DEPTH];
   logic                     bank_q;
   logic [DEPTH-1:0]         we0_hit;
   logic [DEPTH-1:0]         we1_hit;
   logic [NUM_RD*DATA_W-1:0] rd_val_w;

   // Per-entry write decode; register 0 never matches when it is hardwired to zero.
   always_comb begin
      we0_hit = '0;
      we1_hit = '0;
      for (int i = 0; i < DEPTH; i++) begin
         we0_hit[i] = bus.wen0 && (bus.waddr0 == ADDR_W'(i));
         we1_hit[i] = bus.wen1 && (bus.waddr1 == ADDR_W'(i));
      end
      if (ZERO_REG != 0) begin
         we0_hit[0] = 1'b0;
         we1_hit[0] = 1'b0;
      end
   end

   // Only the active bank is written; port 1 wins an address collision.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < DEPTH; i++) begin
               mem[b][i] <= '0;
            end
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (we1_hit[i]) begin
               mem[bank_q][i] <= bus.wdata1;
            end else if (we0_hit[i]) begin
               mem[bank_q][i] <= bus.wdata0;
            end
         end
      end
   end

   // The swap edge still reads and writes the old bank; the new bank is used from the next cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bank_q <= 1'b0;
      end else begin
         bank_q <= bank_q ^ bus.swap;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] stored;
      logic [DATA_W-1:0] fwd;
      logic [DATA_W-1:0] q;
      logic              hit0;
      logic              hit1;
      logic              is_zero;

      assign addr    = bus.rd_addr[p*ADDR_W +: ADDR_W];
      assign stored  = mem[bank_q][addr];
      assign hit0    = (BYPASS != 0) && bus.wen0 && (bus.waddr0 == addr);
      assign hit1    = (BYPASS != 0) && bus.wen1 && (bus.waddr1 == addr);
      assign is_zero = (ZERO_REG != 0) && (addr == '0);

      // Zero register overrides forwarding so a dropped write never leaks through the bypass.
      always_comb begin
         if (is_zero) begin
            fwd = '0;
         end else if (hit1) begin
            fwd = bus.wdata1;
         end else if (hit0) begin
            fwd = bus.wdata0;
         end else begin
            fwd = stored;
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            q <= '0;
         end else if (bus.rd_en[p]) begin
            q <= fwd;
         end
      end

      assign rd_val_w[p*DATA_W +: DATA_W] = q;
   end

   assign bus.rd_val_o = rd_val_w;
   assign bus.bank_o   = bank_q;

endmodule

// File: tb/tb_reg_file_banked.sv
// Bench for reg_file_banked: two instances (bypass + zero reg, read-first plain) driven in lockstep,
// directed vector table, reset sequence, then random traffic against an array-based reference model.
module tb_reg_file_banked;
   localparam int DW    = 16;
   localparam int AW    = 5;
   localparam int NR    = 4;
   localparam int DEPTH = 1 << AW;
   localparam int SW    = 2 + 2 * NR * DW;
   localparam int NVEC  = 19;

   typedef struct {
      logic          wen0;
      logic [AW-1:0] wa0;
      logic [DW-1:0] wd0;
      logic          wen1;
      logic [AW-1:0] wa1;
      logic [DW-1:0] wd1;
      logic [NR-1:0] ren;
      logic [NR*AW-1:0] ra;
      logic          swap;
   } stim_t;

   typedef struct {
      stim_t            s;
      logic [NR*DW-1:0] ea;
      logic [NR*DW-1:0] eb;
      logic             ebank;
   } vec_t;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   total   = 0;
   int   bad     = 0;

   logic [SW-1:0] exp_q[$];
   logic [DW-1:0] mdl_mem [2][2][DEPTH];
   logic [DW-1:0] mdl_out [2][NR];
   logic          mdl_bank;
   vec_t          vt [NVEC];

   reg_file_banked_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_a ();
   reg_file_banked_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_b ();

   reg_file_banked #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1), .ZERO_REG(1)) dut_a (
      .clk(clk), .reset_n(reset_n), .bus(bus_a)
   );
   reg_file_banked #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0), .ZERO_REG(0)) dut_b (
      .clk(clk), .reset_n(reset_n), .bus(bus_b)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000ns, want finish");
      $fatal(1, "watchdog expired");
   end

   function automatic stim_t mk_s(input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                  input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                  input logic [NR-1:0] ren, input logic [NR*AW-1:0] ra, input logic sw);
      stim_t s;
      s.wen0 = w0; s.wa0 = a0; s.wd0 = d0;
      s.wen1 = w1; s.wa1 = a1; s.wd1 = d1;
      s.ren  = ren; s.ra = ra; s.swap = sw;
      return s;
   endfunction

   function automatic vec_t mk_v(input stim_t s, input logic [NR*DW-1:0] ea, input logic [NR*DW-1:0] eb,
                                 input logic bk);
      vec_t v;
      v.s = s; v.ea = ea; v.eb = eb; v.ebank = bk;
      return v;
   endfunction

   function automatic logic [NR*AW-1:0] ra4(input logic [AW-1:0] a3, input logic [AW-1:0] a2,
                                           input logic [AW-1:0] a1, input logic [AW-1:0] a0);
      return {a3, a2, a1, a0};
   endfunction

   // driver tasks
   task automatic apply(input stim_t s);
      bus_a.wen0 = s.wen0; bus_a.waddr0 = s.wa0; bus_a.wdata0 = s.wd0;
      bus_a.wen1 = s.wen1; bus_a.waddr1 = s.wa1; bus_a.wdata1 = s.wd1;
      bus_a.rd_en = s.ren; bus_a.rd_addr = s.ra; bus_a.swap = s.swap;
      bus_b.wen0 = s.wen0; bus_b.waddr0 = s.wa0; bus_b.wdata0 = s.wd0;
      bus_b.wen1 = s.wen1; bus_b.waddr1 = s.wa1; bus_b.wdata1 = s.wd1;
      bus_b.rd_en = s.ren; bus_b.rd_addr = s.ra; bus_b.swap = s.swap;
   endtask

   task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   // reference model: instance 0 = write-first with zero reg, instance 1 = read-first
   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < DEPTH; i++) mdl_mem[d][b][i] = '0;
         for (int p = 0; p < NR; p++) mdl_out[d][p] = '0;
      end
      mdl_bank = 1'b0;
   endtask

   function automatic logic [NR*DW-1:0] pack_out(input int d);
      logic [NR*DW-1:0] r;
      for (int p = 0; p < NR; p++) r[p*DW +: DW] = mdl_out[d][p];
      return r;
   endfunction

   task automatic model_step(input stim_t s);
      logic [AW-1:0] a;
      logic [DW-1:0] v;
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < NR; p++) begin
            if (s.ren[p]) begin
               a = s.ra[p*AW +: AW];
               v = mdl_mem[d][mdl_bank][a];
               if (d == 0) begin
                  if (s.wen1 && s.wa1 == a) v = s.wd1;
                  else if (s.wen0 && s.wa0 == a) v = s.wd0;
                  if (a == 0) v = '0;
               end
               mdl_out[d][p] = v;
            end
         end
         if (s.wen0 && !(d == 0 && s.wa0 == 0)) mdl_mem[d][mdl_bank][s.wa0] = s.wd0;
         if (s.wen1 && !(d == 0 && s.wa1 == 0)) mdl_mem[d][mdl_bank][s.wa1] = s.wd1;
      end
      mdl_bank = mdl_bank ^ s.swap;
      exp_q.push_back({mdl_bank, mdl_bank, pack_out(1), pack_out(0)});
   endtask

   // scoreboard
   task automatic sb_check(input string tag);
      logic [SW-1:0] act;
      logic [SW-1:0] want;
      act = {bus_b.bank_o, bus_a.bank_o, bus_b.rd_val_o, bus_a.rd_val_o};
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: got %h want queued expectation (queue empty)", tag, act);
      end else begin
         want = exp_q.pop_front();
         chk(tag, act, want);
      end
   endtask

   task automatic drive(input stim_t s, input string tag);
      apply(s);
      model_step(s);
      @(posedge clk);
      #1;
      sb_check(tag);
   endtask

   initial begin
      stim_t idle;
      stim_t rs;
      idle = mk_s(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, 4'b0000, ra4(5'd0, 5'd0, 5'd0, 5'd0), 1'b0);
      apply(idle);
      model_reset();

      // reset state held while reset_n is low
      #12;
      chk("reset_rd_a", SW'(bus_a.rd_val_o), '0);
      chk("reset_rd_b", SW'(bus_b.rd_val_o), '0);
      chk("reset_bank_a", SW'(bus_a.bank_o), '0);
      chk("reset_bank_b", SW'(bus_b.bank_o), '0);
      #11 reset_n = 1'b1;

      // directed table: ea = write-first/zero-reg instance, eb = read-first instance
      vt[0]  = mk_v(mk_s(1, 5'd5, 16'h003C, 0, 5'd0, 16'h0, 4'b0001, ra4(0, 0, 0, 5'd5), 0),
                    64'h0000_0000_0000_003C, 64'h0000_0000_0000_0000, 0);
      vt[1]  = mk_v(mk_s(0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 4'b0001, ra4(0, 0, 0, 5'd5), 0),
                    64'h0000_0000_0000_003C, 64'h0000_0000_0000_003C, 0);
      vt[2]  = mk_v(mk_s(1, 5'd7, 16'h0011, 1, 5'd7, 16'h0022, 4'b0011, ra4(0, 0, 5'd5, 5'd7), 0),
                    64'h0000_0000_003C_0022, 64'h0000_0000_003C_0000, 0);
      vt[3]  = mk_v(mk_s(0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 4'b0001, ra4(0, 0, 0, 5'd7), 0),
                    64'h0000_0000_003C_0022, 64'h0000_0000_003C_0022, 0);
      vt[4]  = mk_v(mk_s(1, 5'd0, 16'h00FF, 0, 5'd0, 16'h0, 4'b0011, ra4(0, 0, 5'd7, 5'd0), 0),
                    64'h0000_0000_0022_0000, 64'h0000_0000_0022_0000, 0);
      vt[5]  = mk_v(mk_s(0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 4'b0001, ra4(0, 0, 0, 5'd0), 0),
                    64'h0000_0000_0022_0000, 64'h0000_0000_0022_00FF, 0);
      vt[6]  = mk_v(mk_s(0, 5'd0, 16'h0, 1, 5'd4, 16'h009A, 4'b0000, ra4(0, 0, 0, 0), 0),
                    64'h0000_0000_0022_0000, 64'h0000_0000_0022_00FF, 0);
      vt[7]  = mk_v(mk_s(0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 4'b0010, ra4(0, 0, 5'd4, 0), 0),
                    64'h0000_0000_009A_0000, 64'h0000_0000_009A_00FF, 0);
      vt[8]  = mk_v(mk_s(1, 5'd4, 16'h7777, 0, 5'd0, 16'h0, 4'b0000, ra4(0, 0, 5'd9, 0), 0),
                    64'h0000_0000_009A_0000, 64'h0000_0000_009A_00FF, 0);
      vt[9]  = mk_v(mk_s(1, 5'd2, 16'h0055, 0, 5'd0, 16'h0, 4'b0000, ra4(0, 0, 0, 0), 0),
                    64'h0000_0000_009A_0000, 64'h0000_0000_009A_00FF, 0);
      vt[10] = mk_v(mk_s(1, 5'd2, 16'h0066, 0, 5'd0, 16'h0, 4'b0001, ra4(0, 0, 0, 5'd2), 1),
                    64'h0000_0000_009A_0066, 64'h0000_0000_009A_0055, 1);
      vt[11] = mk_v(mk_s(0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 4'b0001, ra4(0, 0, 0, 5'd2), 0),
                    64'h0000_0000_009A_0000, 64'h0000_0000_009A_0000, 1);
      vt[12] = mk_v(mk_s(0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 4'b0001, ra4(0, 0, 0, 5'd2), 1),
                    64'h0000_0000_009A_0000, 64'h0000_0000_009A_0000, 0);
      vt[13] = mk_v(mk_s(0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 4'b0001, ra4(0, 0, 0, 5'd2), 0),
                    64'h0000_0000_009A_0066, 64'h0000_0000_009A_0066, 0);
      vt[14] = mk_v(mk_s(0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 4'b0000, ra4(0, 0, 0, 0), 1),
                    64'h0000_0000_009A_0066, 64'h0000_0000_009A_0066, 1);
      vt[15] = mk_v(mk_s(0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 4'b0000, ra4(0, 0, 0, 0), 1),
                    64'h0000_0000_009A_0066, 64'h0000_0000_009A_0066, 0);
      vt[16] = mk_v(mk_s(1, 5'd31, 16'h1234, 1, 5'd30, 16'hBEEF, 4'b0000, ra4(0, 0, 0, 0), 0),
                    64'h0000_0000_009A_0066, 64'h0000_0000_009A_0066, 0);
      vt[17] = mk_v(mk_s(1, 5'd29, 16'h0001, 1, 5'd28, 16'hFFFF, 4'b1111, ra4(5'd28, 5'd29, 5'd30, 5'd31), 0),
                    64'hFFFF_0001_BEEF_1234, 64'h0000_0000_BEEF_1234, 0);
      vt[18] = mk_v(mk_s(0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 4'b1111, ra4(5'd28, 5'd29, 5'd30, 5'd31), 0),
                    64'hFFFF_0001_BEEF_1234, 64'hFFFF_0001_BEEF_1234, 0);

      for (int i = 0; i < NVEC; i++) begin
         drive(vt[i].s, $sformatf("sb_vec%0d", i));
         chk($sformatf("vec%0d_rd_a", i), SW'(bus_a.rd_val_o), SW'(vt[i].ea));
         chk($sformatf("vec%0d_rd_b", i), SW'(bus_b.rd_val_o), SW'(vt[i].eb));
         chk($sformatf("vec%0d_bank", i), SW'(bus_a.bank_o), SW'(vt[i].ebank));
      end

      // asynchronous reset mid-cycle: r3 = 0xA5 in both banks, leave bank 1 active
      drive(mk_s(1, 5'd3, 16'h00A5, 0, 5'd0, 16'h0, 4'b0000, ra4(0, 0, 0, 0), 1), "sb_rst_w0");
      drive(mk_s(1, 5'd3, 16'h00A5, 0, 5'd0, 16'h0, 4'b0000, ra4(0, 0, 0, 0), 0), "sb_rst_w1");
      drive(mk_s(0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 4'b0011, ra4(0, 0, 5'd3, 5'd3), 0), "sb_rst_rd");
      chk("pre_rst_rd_a", SW'(bus_a.rd_val_o[31:0]), SW'(32'h00A5_00A5));
      apply(idle);
      #3 reset_n = 1'b0;
      #1;
      chk("async_rst_rd_a", SW'(bus_a.rd_val_o), '0);
      chk("async_rst_rd_b", SW'(bus_b.rd_val_o), '0);
      chk("async_rst_bank_a", SW'(bus_a.bank_o), '0);
      chk("async_rst_bank_b", SW'(bus_b.bank_o), '0);
      model_reset();
      @(posedge clk);
      #3 reset_n = 1'b1;
      drive(mk_s(0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 4'b0001, ra4(0, 0, 0, 5'd3), 0), "sb_post_rst_b0");
      chk("post_rst_r3_bank0_a", SW'(bus_a.rd_val_o[15:0]), '0);
      chk("post_rst_r3_bank0_b", SW'(bus_b.rd_val_o[15:0]), '0);
      drive(mk_s(0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 4'b0000, ra4(0, 0, 0, 0), 1), "sb_post_rst_sw");
      drive(mk_s(0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 4'b0001, ra4(0, 0, 0, 5'd3), 1), "sb_post_rst_b1");
      chk("post_rst_r3_bank1_b", SW'(bus_b.rd_val_o[15:0]), '0);
      chk("post_rst_bank", SW'(bus_b.bank_o), '0);

      // random traffic biased to low addresses for collisions, bypass hits and r0
      for (int n = 0; n < 400; n++) begin
         rs.wen0 = 1'($urandom_range(0, 1));
         rs.wa0  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
         rs.wd0  = DW'($urandom);
         rs.wen1 = 1'($urandom_range(0, 1));
         rs.wa1  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
         rs.wd1  = DW'($urandom);
         rs.ren  = NR'($urandom);
         for (int p = 0; p < NR; p++) rs.ra[p*AW +: AW] = AW'($urandom_range(0, 7));
         rs.swap = ($urandom_range(0, 7) == 0);
         drive(rs, $sformatf("sb_rand%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_file_banked.md
# reg_file_banked

Parametrised successor to the 8-bit, 16-entry register file. It adds configurable data width, address width and read-port count, plus a second write port, per-port read enables and optional write-to-read bypass. It also provides a hardwired-zero register option and two architectural banks with single-cycle bank swap for interrupt context. The block sits between decode and the ALU/load-store path. Reads are registered with 1-cycle latency, as in the previous generation, and all state has an asynchronous clear.

## Interface
- DATA_W, default 8: register width in bits.
- ADDR_W, default 4: address width; 2**ADDR_W registers per bank.
- NUM_RD, default 2: number of read ports, 1..4.
- BYPASS, default 1: 1 = write-first forwarding; 0 = read-first (old data).
- ZERO_REG, default 0: 1 = register 0 always reads 0 and ignores writes.

- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rd_en  in  NUM_RD  per-port read enable.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
- rd_val_o  out  NUM_RD*DATA_W  registered read data; port p occupies bits [p*DATA_W +: DATA_W].
- wen0, wen1  in  1 each  write enables for write ports 0 and 1.
- waddr0, waddr1  in  ADDR_W each  write addresses.
- wdata0, wdata1  in  DATA_W each  write data.
- swap  in  1  single-cycle pulse; toggles the active bank.
- bank_o  out  1  currently active bank.

## Operation
- Storage is two banks of 2**ADDR_W x DATA_W. All reads and writes address the active bank only; the inactive bank is untouched.
- Reset (reset_n low, asynchronous): every register in both banks = 0, rd_val_o = 0, bank_o = 0. State holds while reset_n stays low.
- Write: on a rising edge with wenN=1, the active bank's wdataN is stored at waddrN.
- Write collision (wen0 = wen1 = 1, waddr0 == waddr1): port 1 wins; wdata0 is discarded.
- ZERO_REG=1: writes to address 0 are dropped. Reads of address 0 return 0 regardless of bypass.
- Read, port p, on a rising edge:
  - rd_en[p]=1: rd_val_o[p] loads the value of rd_addr[p].
  - rd_en[p]=0: rd_val_o[p] holds its previous value.
- Bypass, BYPASS=1: if a write in the same cycle targets rd_addr[p], rd_val_o[p] loads the incoming write data. Port 1 takes priority when both write ports match.
- Bypass, BYPASS=0: rd_val_o[p] loads the pre-write stored value.
- Swap: on a rising edge with swap=1, bank_o toggles.
  - Reads and writes in that same cycle use the pre-swap bank.
  - Operations from the next cycle use the new bank.
  - Back-to-back swap pulses toggle every cycle.
- Address width is exact; there is no out-of-range address.

## Timing
- Read latency: 1 cycle. Address presented in cycle N appears on rd_val_o after edge N, valid for all of cycle N+1.
- Write-to-read, same address:
  - Read issued one cycle after the write edge returns the new data in both BYPASS modes.
  - Read issued in the same cycle returns new data only if BYPASS=1.
- bank_o updates on the swap edge. Storage is not copied between banks on swap.
- Reset mid-operation: pending writes are lost; outputs go to 0 immediately (asynchronously), not at the next edge.
- First edge after reset_n rises behaves normally. No outputs are combinational from inputs.

## Test plan
- Reset/clear: write 0xA5 to r3 in both banks, pulse reset_n low mid-cycle. rd_val_o goes to 0 without waiting for an edge. After release, reading r3 in either bank returns 0x00 and bank_o = 0.
- Bypass modes: write r5=0x3C with port 0 read of r5 in the same cycle.
  - BYPASS=1: rd_val_o[0] = 0x3C next cycle.
  - BYPASS=0: rd_val_o[0] = previous 0x00; a re-read the following cycle returns 0x3C.
- Dual-write collision: wen0=wen1=1, both to r7, wdata0=0x11, wdata1=0x22. Read r7 -> 0x22. With BYPASS=1, a same-cycle read of r7 also -> 0x22.
- Bank swap: in bank 0 write r2=0x55. Pulse swap together with a write r2=0x66; the write lands in bank 0.
  - Next cycle: bank_o = 1 and read r2 -> 0x00.
  - Pulse swap again: read r2 -> 0x66.
- Read-enable hold and zero register:
  - Read r4=0x9A, then drop rd_en[1] and change rd_addr[1]; rd_val_o[1] stays 0x9A.
  - ZERO_REG=1: write r0=0xFF, then read r0 -> 0x00, including a same-cycle bypass read.
- Multi-port, NUM_RD=4, DATA_W=16, ADDR_W=5: fill r31..r28 with 0x1234, 0xBEEF, 0x0001, 0xFFFF. Read all four ports simultaneously -> each value on its own port slice, one cycle later.
